// File: rtl/edc_correct_stage.sv
// ---------------------------------------------------------------------------
// edc_correct_stage
//
// Registered SEC-DED check/correct stage placed directly behind the EDC
// generator on the main-memory read-return path. It takes the raw read word,
// its stored check bits and the generator's read-mode syndrome. It emits the
// corrected word together with an error classification. It also keeps
// saturating single/double error counters and a sticky address of the first
// uncorrectable word.
//
// Pipeline: S1 captures the inputs, S2 holds the decoded result. Both stages
// shift together whenever the output is empty or being taken
// (advance = !o_valid | i_ready). A word therefore reaches o_valid two
// cycles after it is presented.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid / o_ready   upstream handshake
//   i_data              raw 32-bit read data
//   i_check             stored 8 check bits
//   i_syndrome          8-bit syndrome from the EDC generator
//   i_addr              address tag travelling with the word
//   o_valid / i_ready   downstream handshake
//   o_data              corrected data
//   o_single_err        correctable error (data or check bit)
//   o_double_err        uncorrectable error
//   o_err_bit           [5]=check-bit error, [4:0]=bit index, 0 otherwise
//   o_single_cnt        saturating count of correctable words
//   o_double_cnt        saturating count of uncorrectable words
//   i_cnt_clr           synchronous clear of counters and sticky address
//   o_ue_addr           address of the first uncorrectable word since clear
//   o_ue_valid          o_ue_addr holds a captured address
//
// Optional feature (macro EDC_SCRUB_EN):
//   o_scrub_req, o_scrub_addr, o_scrub_data, o_scrub_check, i_scrub_ack,
//   o_scrub_ovf. These issue one write-back request with the corrected word
//   for every correctable error. A correctable word that arrives while a
//   request is still outstanding sets o_scrub_ovf. The scrub logic never
//   stalls the data path.
// ---------------------------------------------------------------------------
module edc_correct_stage #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_data,
  input  logic [7:0]        i_check,
  input  logic [7:0]        i_syndrome,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_data,
  output logic              o_single_err,
  output logic              o_double_err,
  output logic [5:0]        o_err_bit,
  output logic [CNT_W-1:0]  o_single_cnt,
  output logic [CNT_W-1:0]  o_double_cnt,
  input  logic              i_cnt_clr,
  output logic [ADDR_W-1:0] o_ue_addr,
  output logic              o_ue_valid
`ifdef EDC_SCRUB_EN
  ,
  output logic              o_scrub_req,
  output logic [ADDR_W-1:0] o_scrub_addr,
  output logic [31:0]       o_scrub_data,
  output logic [7:0]        o_scrub_check,
  input  logic              i_scrub_ack,
  output logic              o_scrub_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // H-matrix column of data bit idx. The low half puts one bit in S[3:0]
  // and two in S[7:4]; the high half mirrors that. All 32 columns are
  // therefore distinct weight-3 patterns, disjoint from check-bit columns.
  function automatic logic [7:0] dataColumn(input int unsigned idx);
    int unsigned j;
    int unsigned n;
    logic [7:0]  col;
    if (idx < 16) begin
      j   = idx % 4;
      n   = idx / 4;
      col = (8'd1 << j) | (8'd1 << (4 + (n >> 1))) | (8'd1 << (6 + (n & 1)));
    end else begin
      j   = (idx - 16) % 4;
      n   = (idx - 16) / 4;
      col = (8'd1 << (4 + j)) | (8'd1 << (n >> 1)) | (8'd1 << (2 + (n & 1)));
    end
    return col;
  endfunction

  // Handshake
  logic advance;
  logic loadS2;

  // Stage 1: captured inputs
  logic              s1Valid_q;
  logic [31:0]       s1Data_q;
  logic [7:0]        s1Syn_q;
  logic [ADDR_W-1:0] s1Addr_q;

  // Stage 2: decoded result
  logic              s2Valid_q;
  logic [31:0]       s2Data_q,      s2Data_d;
  logic              s2Single_q,    s2Single_d;
  logic              s2Double_q,    s2Double_d;
  logic [5:0]        s2ErrBit_q,    s2ErrBit_d;

  // Counters and sticky uncorrectable address
  logic [CNT_W-1:0]  singleCnt_q,   singleCnt_d;
  logic [CNT_W-1:0]  doubleCnt_q,   doubleCnt_d;
  logic [ADDR_W-1:0] ueAddr_q,      ueAddr_d;
  logic              ueValid_q,     ueValid_d;

  // Syndrome analysis
  logic [3:0]        synWeight;
  logic [2:0]        checkIdx;
  logic              colHit;
  logic [4:0]        colIdx;

  // The whole pipe moves as one unit. It stops only while a finished word
  // sits in S2 and downstream refuses it. A word in S2 is loaded exactly
  // once, so it is counted exactly once.
  assign advance = !s2Valid_q | i_ready;
  assign o_ready = advance;
  assign loadS2  = advance & s1Valid_q;

  // S1 simply latches whatever upstream presents whenever the pipe moves.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Syn_q   <= '0;
      s1Addr_q  <= '0;
    end else if (advance) begin
      s1Valid_q <= i_valid;
      s1Data_q  <= i_data;
      s1Syn_q   <= i_syndrome;
      s1Addr_q  <= i_addr;
    end
  end

  // Weight of the syndrome, plus the position of the (last) set bit. That
  // position is the failing check bit when the weight is exactly one.
  always_comb begin
    synWeight = '0;
    checkIdx  = '0;
    for (int k = 0; k < 8; k++) begin
      synWeight = synWeight + {3'b000, s1Syn_q[k]};
      if (s1Syn_q[k]) checkIdx = 3'(k);
    end
  end

  // Look the syndrome up among the 32 data-bit columns.
  always_comb begin
    colHit = 1'b0;
    colIdx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (s1Syn_q == dataColumn(i)) begin
        colHit = 1'b1;
        colIdx = 5'(i);
      end
    end
  end

  // Classify the word. An odd-weight syndrome that is neither a check-bit
  // column nor a data column can only come from three or more flips. It is
  // reported as uncorrectable, just like every even non-zero weight.
  always_comb begin
    s2Data_d   = s1Data_q;
    s2Single_d = 1'b0;
    s2Double_d = 1'b0;
    s2ErrBit_d = '0;
    if (s1Syn_q != 8'h00) begin
      if (synWeight == 4'd1) begin
        s2Single_d = 1'b1;
        s2ErrBit_d = {1'b1, 2'b00, checkIdx};
      end else if ((synWeight == 4'd3) && colHit) begin
        s2Data_d   = s1Data_q ^ (32'd1 << colIdx);
        s2Single_d = 1'b1;
        s2ErrBit_d = {1'b0, colIdx};
      end else begin
        s2Double_d = 1'b1;
      end
    end
  end

  // S2 holds the decoded word and keeps it frozen while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2Valid_q  <= 1'b0;
      s2Data_q   <= '0;
      s2Single_q <= 1'b0;
      s2Double_q <= 1'b0;
      s2ErrBit_q <= '0;
    end else if (advance) begin
      s2Valid_q  <= s1Valid_q;
      s2Data_q   <= s2Data_d;
      s2Single_q <= s2Single_d;
      s2Double_q <= s2Double_d;
      s2ErrBit_q <= s2ErrBit_d;
    end
  end

  // Counters bump when a flagged word lands in S2 and saturate at all-ones.
  // A clear in the same cycle wins and leaves the counter at zero.
  always_comb begin
    singleCnt_d = singleCnt_q;
    doubleCnt_d = doubleCnt_q;
    if (i_cnt_clr) begin
      singleCnt_d = '0;
      doubleCnt_d = '0;
    end else begin
      if (loadS2 && s2Single_d && (singleCnt_q != CNT_MAX)) begin
        singleCnt_d = singleCnt_q + 1'b1;
      end
      if (loadS2 && s2Double_d && (doubleCnt_q != CNT_MAX)) begin
        doubleCnt_d = doubleCnt_q + 1'b1;
      end
    end
  end

  // The sticky address keeps the first uncorrectable word since the last
  // clear. A capture coinciding with a clear is that first word, so the
  // capture beats the clear.
  always_comb begin
    ueAddr_d  = ueAddr_q;
    ueValid_d = ueValid_q;
    if (loadS2 && s2Double_d && (!ueValid_q || i_cnt_clr)) begin
      ueAddr_d  = s1Addr_q;
      ueValid_d = 1'b1;
    end else if (i_cnt_clr) begin
      ueAddr_d  = '0;
      ueValid_d = 1'b0;
    end
  end

  // Statistics registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      singleCnt_q <= '0;
      doubleCnt_q <= '0;
      ueAddr_q    <= '0;
      ueValid_q   <= 1'b0;
    end else begin
      singleCnt_q <= singleCnt_d;
      doubleCnt_q <= doubleCnt_d;
      ueAddr_q    <= ueAddr_d;
      ueValid_q   <= ueValid_d;
    end
  end

  assign o_valid      = s2Valid_q;
  assign o_data       = s2Data_q;
  assign o_single_err = s2Single_q;
  assign o_double_err = s2Double_q;
  assign o_err_bit    = s2ErrBit_q;
  assign o_single_cnt = singleCnt_q;
  assign o_double_cnt = doubleCnt_q;
  assign o_ue_addr    = ueAddr_q;
  assign o_ue_valid   = ueValid_q;

`ifdef EDC_SCRUB_EN
  logic [7:0]        s1Check_q;
  logic              scrubReq_q,   scrubReq_d;
  logic [ADDR_W-1:0] scrubAddr_q,  scrubAddr_d;
  logic [31:0]       scrubData_q,  scrubData_d;
  logic [7:0]        scrubCheck_q, scrubCheck_d;
  logic              scrubOvf_q,   scrubOvf_d;

  // The stored check bits are only needed to rebuild a repaired check field.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1Check_q <= '0;
    end else if (advance) begin
      s1Check_q <= i_check;
    end
  end

  // One outstanding write-back at a time. The repaired check field flips
  // the failing check bit only for a check-bit error; for a data-bit error
  // the stored check bits were already right. A correctable word that finds
  // the slot busy is dropped and noted in the sticky overflow flag.
  always_comb begin
    scrubReq_d   = scrubReq_q;
    scrubAddr_d  = scrubAddr_q;
    scrubData_d  = scrubData_q;
    scrubCheck_d = scrubCheck_q;
    scrubOvf_d   = scrubOvf_q;
    if (scrubReq_q && i_scrub_ack) scrubReq_d = 1'b0;
    if (i_cnt_clr) scrubOvf_d = 1'b0;
    if (loadS2 && s2Single_d) begin
      if (!scrubReq_q) begin
        scrubReq_d   = 1'b1;
        scrubAddr_d  = s1Addr_q;
        scrubData_d  = s2Data_d;
        scrubCheck_d = s1Check_q ^ ((synWeight == 4'd1) ? s1Syn_q : 8'h00);
      end else begin
        scrubOvf_d = 1'b1;
      end
    end
  end

  // Scrub request registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scrubReq_q   <= 1'b0;
      scrubAddr_q  <= '0;
      scrubData_q  <= '0;
      scrubCheck_q <= '0;
      scrubOvf_q   <= 1'b0;
    end else begin
      scrubReq_q   <= scrubReq_d;
      scrubAddr_q  <= scrubAddr_d;
      scrubData_q  <= scrubData_d;
      scrubCheck_q <= scrubCheck_d;
      scrubOvf_q   <= scrubOvf_d;
    end
  end

  assign o_scrub_req   = scrubReq_q;
  assign o_scrub_addr  = scrubAddr_q;
  assign o_scrub_data  = scrubData_q;
  assign o_scrub_check = scrubCheck_q;
  assign o_scrub_ovf   = scrubOvf_q;
`else
  // Without scrubbing the stored check bits carry no information we need.
  logic unusedCheck;
  assign unusedCheck = ^i_check;
`endif

endmodule

// File: tb/tb_edc_correct_stage.sv
// ---------------------------------------------------------------------------
// tb_edc_correct_stage
//
// Directed bench for edc_correct_stage. Each word is described by the error
// that was injected into it: a clean word, a flipped data bit, a flipped
// check bit, or two flips. The expected output follows from that
// description. The syndrome driven into the DUT is built from the H-matrix
// column table. A scoreboard queue holds the expected words, and a compare
// process checks every valid output cycle against it, including the counters
// and the sticky address.
// ---------------------------------------------------------------------------
module tb_edc_correct_stage;

  localparam int TB_CNT_W  = 4;
  localparam int TB_ADDR_W = 32;
  localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_valid;
  logic                 o_ready;
  logic [31:0]          i_data;
  logic [7:0]           i_check;
  logic [7:0]           i_syndrome;
  logic [TB_ADDR_W-1:0] i_addr;
  logic                 o_valid;
  logic                 i_ready;
  logic [31:0]          o_data;
  logic                 o_single_err;
  logic                 o_double_err;
  logic [5:0]           o_err_bit;
  logic [TB_CNT_W-1:0]  o_single_cnt;
  logic [TB_CNT_W-1:0]  o_double_cnt;
  logic                 i_cnt_clr;
  logic [TB_ADDR_W-1:0] o_ue_addr;
  logic                 o_ue_valid;

  edc_correct_stage #(.CNT_W(TB_CNT_W), .ADDR_W(TB_ADDR_W)) dut (
    .i_clk(clock), .i_rst(reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_check(i_check), .i_syndrome(i_syndrome), .i_addr(i_addr),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_single_err(o_single_err), .o_double_err(o_double_err),
    .o_err_bit(o_err_bit), .o_single_cnt(o_single_cnt), .o_double_cnt(o_double_cnt),
    .i_cnt_clr(i_cnt_clr), .o_ue_addr(o_ue_addr), .o_ue_valid(o_ue_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        single;
    logic        dbl;
    logic [5:0]  errBit;
    logic [31:0] addr;
    logic        uncounted;
  } expT;

  expT         expQ[$];
  int          vectorCount = 0;
  int          missCount = 0;
  int          singleSeen = 0;
  int          doubleSeen = 0;
  logic        ueSeen = 1'b0;
  logic [31:0] ueSeenAddr = '0;
  logic        nextUncounted = 1'b0;
  logic [31:0] addrNext = 32'h1000;

  // Compare-process working variables
  expT         cmpE;
  int          cmpS;
  int          cmpD;
  logic        cmpUeV;
  logic [31:0] cmpUeA;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // H-matrix column of data bit b, straight from the column rule.
  function automatic logic [7:0] colOf(input int b);
    int j;
    int n;
    logic [7:0] s;
    if (b < 16) begin
      j = b % 4;
      n = b / 4;
      s = 8'(1 << j) | 8'(1 << (4 + n / 2)) | 8'(1 << (6 + n % 2));
    end else begin
      j = (b - 16) % 4;
      n = (b - 16) / 4;
      s = 8'(1 << (4 + j)) | 8'(1 << (n / 2)) | 8'(1 << (2 + n % 2));
    end
    return s;
  endfunction

  // Offer one word, wait (bounded) until it is accepted, record expectation.
  task automatic applyStimulus(input logic [31:0] raw, input logic [7:0] syn,
                               input logic [31:0] addr, input logic [31:0] expData,
                               input logic expS, input logic expD, input logic [5:0] expEb);
    expT e;
    logic accepted;
    accepted = 1'b0;
    @(negedge clock);
    i_valid    = 1'b1;
    i_data     = raw;
    i_syndrome = syn;
    i_check    = syn ^ 8'h3C;
    i_addr     = addr;
    for (int c = 0; c < 100; c++) begin
      #4;
      accepted = o_ready;
      @(posedge clock);
      if (accepted) break;
      @(negedge clock);
    end
    #1;
    i_valid = 1'b0;
    if (accepted) begin
      e.data = expData; e.single = expS; e.dbl = expD; e.errBit = expEb;
      e.addr = addr; e.uncounted = nextUncounted;
      expQ.push_back(e);
    end else begin
      checkOutput("accept_timeout", {63'd0, accepted}, 64'd1);
    end
  endtask

  task automatic injectClean(input logic [31:0] d);
    applyStimulus(d, 8'h00, addrNext, d, 1'b0, 1'b0, 6'h00);
    addrNext += 4;
  endtask

  task automatic injectData(input logic [31:0] d, input int b);
    applyStimulus(d ^ (32'd1 << b), colOf(b), addrNext, d, 1'b1, 1'b0, {1'b0, 5'(b)});
    addrNext += 4;
  endtask

  task automatic injectCheck(input logic [31:0] d, input int k);
    applyStimulus(d, 8'(1 << k), addrNext, d, 1'b1, 1'b0, {1'b1, 2'b00, 3'(k)});
    addrNext += 4;
  endtask

  task automatic injectDouble(input logic [31:0] d, input int a, input int b,
                              input logic [31:0] addr);
    logic [31:0] raw;
    raw = d ^ (32'd1 << a) ^ (32'd1 << b);
    applyStimulus(raw, colOf(a) ^ colOf(b), addr, raw, 1'b0, 1'b1, 6'h00);
  endtask

  task automatic injectDataCheck(input logic [31:0] d, input int a, input int k);
    logic [31:0] raw;
    raw = d ^ (32'd1 << a);
    applyStimulus(raw, colOf(a) ^ 8'(1 << k), addrNext, raw, 1'b0, 1'b1, 6'h00);
    addrNext += 4;
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while (expQ.size() != 0 && c < 200) begin
      @(posedge clock);
      c++;
    end
    checkOutput("drain_pending_words", 64'(expQ.size()), 64'd0);
    @(negedge clock);
    #2;
  endtask

  task automatic pulseClear();
    @(negedge clock);
    i_cnt_clr = 1'b1;
    @(posedge clock);
    #1;
    i_cnt_clr  = 1'b0;
    singleSeen = 0;
    doubleSeen = 0;
    ueSeen     = 1'b0;
    #1;
    checkOutput("clr_single_cnt", 64'(o_single_cnt), 64'd0);
    checkOutput("clr_double_cnt", 64'(o_double_cnt), 64'd0);
    checkOutput("clr_ue_valid", {63'd0, o_ue_valid}, 64'd0);
  endtask

  // Compare every cycle that carries an output word, stalled or not.
  always begin
    @(negedge clock);
    #3;
    if (o_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", {63'd0, o_valid}, 64'd0);
      end else begin
        cmpE = expQ[0];
        checkOutput("data", 64'(o_data), 64'(cmpE.data));
        checkOutput("single_err", {63'd0, o_single_err}, {63'd0, cmpE.single});
        checkOutput("double_err", {63'd0, o_double_err}, {63'd0, cmpE.dbl});
        checkOutput("err_bit", 64'(o_err_bit), 64'(cmpE.errBit));
        cmpS = singleSeen + ((cmpE.single && !cmpE.uncounted) ? 1 : 0);
        cmpD = doubleSeen + ((cmpE.dbl && !cmpE.uncounted) ? 1 : 0);
        if (cmpS > CNT_MAX) cmpS = CNT_MAX;
        if (cmpD > CNT_MAX) cmpD = CNT_MAX;
        checkOutput("single_cnt", 64'(o_single_cnt), 64'(cmpS));
        checkOutput("double_cnt", 64'(o_double_cnt), 64'(cmpD));
        cmpUeV = ueSeen | cmpE.dbl;
        cmpUeA = ueSeen ? ueSeenAddr : cmpE.addr;
        checkOutput("ue_valid", {63'd0, o_ue_valid}, {63'd0, cmpUeV});
        if (cmpUeV) checkOutput("ue_addr", 64'(o_ue_addr), 64'(cmpUeA));
        if (i_ready) begin
          if (!cmpE.uncounted) begin
            singleSeen += cmpE.single ? 1 : 0;
            doubleSeen += cmpE.dbl ? 1 : 0;
          end
          if (cmpE.dbl && !ueSeen) begin
            ueSeen     = 1'b1;
            ueSeenAddr = cmpE.addr;
          end
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] patterns [4];
    patterns[0] = 32'h00000000;
    patterns[1] = 32'hFFFFFFFF;
    patterns[2] = 32'hA5A5A5A5;
    patterns[3] = 32'h13579BDF;
    i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    i_data = '0; i_check = '0; i_syndrome = '0; i_addr = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_o_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("rst_o_ready", {63'd0, o_ready}, 64'd1);
    checkOutput("rst_o_data", 64'(o_data), 64'd0);
    checkOutput("rst_err_bit", 64'(o_err_bit), 64'd0);
    checkOutput("rst_single_cnt", 64'(o_single_cnt), 64'd0);
    checkOutput("rst_double_cnt", 64'(o_double_cnt), 64'd0);
    checkOutput("rst_ue_valid", {63'd0, o_ue_valid}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Pin the column table against hand-computed columns
    checkOutput("model_col0", 64'(colOf(0)), 64'h51);
    checkOutput("model_col31", 64'(colOf(31)), 64'h8A);
    checkOutput("model_col16", 64'(colOf(16)), 64'h15);

    // Hand-computed vectors
    applyStimulus(32'h12345678, 8'h00, 32'h10, 32'h12345678, 1'b0, 1'b0, 6'h00);
    applyStimulus(32'h00000001, 8'h51, 32'h14, 32'h00000000, 1'b1, 1'b0, 6'h00);
    applyStimulus(32'h80000000, 8'h8A, 32'h18, 32'h00000000, 1'b1, 1'b0, 6'h1F);
    applyStimulus(32'hCAFEF00D, 8'h04, 32'h1C, 32'hCAFEF00D, 1'b1, 1'b0, 6'h22);
    applyStimulus(32'hDEADBEEF, 8'hDB, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 6'h00);
    applyStimulus(32'h0BADF00D, 8'h07, 32'h200, 32'h0BADF00D, 1'b0, 1'b1, 6'h00);
    waitDrain();
    checkOutput("plan_single_cnt", 64'(o_single_cnt), 64'd3);
    checkOutput("plan_double_cnt", 64'(o_double_cnt), 64'd2);
    checkOutput("plan_ue_addr", 64'(o_ue_addr), 64'h100);
    checkOutput("plan_ue_valid", {63'd0, o_ue_valid}, 64'd1);
    pulseClear();

    // Injected-error sweep over several data patterns
    for (int p = 0; p < 4; p++) begin
      injectClean(patterns[p]);
      for (int b = p; b < 32; b += 9) injectData(patterns[p], b);
      injectCheck(patterns[p], 2 * p);
      injectCheck(patterns[p], 2 * p + 1);
      injectDouble(patterns[p], p, 31 - p, addrNext);
      addrNext += 4;
      injectDataCheck(patterns[p], 20 + p, p + 3);
    end
    waitDrain();

    // Backpressure: three words offered while downstream refuses for 5 cycles
    pulseClear();
    @(negedge clock);
    i_ready = 1'b0;
    fork
      begin
        injectData(32'h11111111, 5);
        injectClean(32'h22222222);
        injectDouble(32'h33333333, 1, 2, 32'h500);
      end
      begin
        repeat (3) @(negedge clock);
        #2;
        checkOutput("bp_o_ready_low", {63'd0, o_ready}, 64'd0);
        checkOutput("bp_o_valid_held", {63'd0, o_valid}, 64'd1);
        repeat (2) @(negedge clock);
        #2;
        i_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_single_once", 64'(o_single_cnt), 64'd1);
    checkOutput("bp_double_once", 64'(o_double_cnt), 64'd1);

    // Clear coinciding with a capture: capture wins, count is cleared
    pulseClear();
    nextUncounted = 1'b1;
    injectDouble(32'h44444444, 3, 9, 32'h300);
    nextUncounted = 1'b0;
    i_cnt_clr = 1'b1;
    @(posedge clock);
    #1;
    i_cnt_clr = 1'b0;
    waitDrain();
    checkOutput("clrcap_ue_valid", {63'd0, o_ue_valid}, 64'd1);
    checkOutput("clrcap_ue_addr", 64'(o_ue_addr), 64'h300);
    checkOutput("clrcap_double_cnt", 64'(o_double_cnt), 64'd0);
    injectDouble(32'h77777777, 0, 30, 32'h400);
    waitDrain();
    checkOutput("ue_not_overwritten", 64'(o_ue_addr), 64'h300);
    checkOutput("double_after_clrcap", 64'(o_double_cnt), 64'd1);

    // Saturation of the single-error counter
    pulseClear();
    for (int i = 0; i < CNT_MAX + 2; i++) injectData(32'h0F0F0F0F, (i * 5) % 32);
    waitDrain();
    checkOutput("single_cnt_saturated", 64'(o_single_cnt), 64'(CNT_MAX));

    // Reset in the middle of a stream drops in-flight words at once
    injectClean(32'h55555555);
    injectClean(32'h66666666);
    reset = 1'b1;
    #1;
    checkOutput("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("midrst_single_cnt", 64'(o_single_cnt), 64'd0);
    expQ.delete();
    singleSeen = 0;
    doubleSeen = 0;
    ueSeen     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    #2;
    checkOutput("postrst_no_output", {63'd0, o_valid}, 64'd0);
    injectData(32'h89ABCDEF, 17);
    waitDrain();
    checkOutput("postrst_single_cnt", 64'(o_single_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
